// File: rtl/pan_zoom_pkg.sv
// Shared types and widths for the pan/zoom address generator.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// The payload structs are sized from the PZ_* constants below. The top-level
// parameters default to these constants and must stay equal to them; to
// retarget the block, edit the constants here.
package pan_zoom_pkg;

  localparam int PZ_FRAME_WIDTH  = 512;
  localparam int PZ_FRAME_HEIGHT = 512;
  localparam int PZ_DISP_WIDTH   = 1024;
  localparam int PZ_DISP_HEIGHT  = 768;
  localparam int PZ_H_W          = 11;
  localparam int PZ_V_W          = 10;
  localparam int PZ_ZOOM_MAX     = 3;

  localparam int PZ_ZOOM_W = $clog2(PZ_ZOOM_MAX + 1);
  localparam int PZ_FX_W   = $clog2(PZ_FRAME_WIDTH);
  localparam int PZ_FY_W   = $clog2(PZ_FRAME_HEIGHT);
  localparam int PZ_ADDR_W = $clog2(PZ_FRAME_WIDTH * PZ_FRAME_HEIGHT);

  // Zoom ceiling, one bit wider than the zoom field so the saturation compare
  // is a real compare even when the field cannot exceed the ceiling.
  localparam logic [PZ_ZOOM_W:0]   PZ_ZOOM_MAX_EXT = PZ_ZOOM_MAX[PZ_ZOOM_W:0];
  localparam logic [PZ_ZOOM_W-1:0] PZ_ZOOM_SAT     = PZ_ZOOM_MAX[PZ_ZOOM_W-1:0];

  typedef enum logic {
    MODE_MASK  = 1'b0,
    MODE_CLAMP = 1'b1
  } clamp_mode_e;

  typedef struct packed {
    logic [PZ_H_W-1:0]    h_off;
    logic [PZ_V_W-1:0]    v_off;
    logic [PZ_ZOOM_W-1:0] zoom;
    clamp_mode_e          clamp;
  } cfg_t;

  // Stage 1 -> stage 2: zoomed display coordinates plus the config snapshot
  // that belongs to this pixel, so a later commit cannot touch it.
  typedef struct packed {
    logic                   win;
    logic [PZ_H_W-1:0]      sx;
    logic [PZ_V_W-1:0]      sy;
    logic [PZ_ZOOM_MAX-1:0] frac_x;
    logic [PZ_ZOOM_MAX-1:0] frac_y;
    logic [PZ_H_W-1:0]      h_off;
    logic [PZ_V_W-1:0]      v_off;
    clamp_mode_e            clamp;
    logic [PZ_H_W-1:0]      hcount;
    logic [PZ_V_W-1:0]      vcount;
  } s1_t;

  // Stage 2 -> stage 3: final frame coordinates, already zeroed when invalid.
  typedef struct packed {
    logic                   vld;
    logic [PZ_FX_W-1:0]     x;
    logic [PZ_FY_W-1:0]     y;
    logic [PZ_ZOOM_MAX-1:0] frac_x;
    logic [PZ_ZOOM_MAX-1:0] frac_y;
    logic [PZ_H_W-1:0]      hcount;
    logic [PZ_V_W-1:0]      vcount;
  } s2_t;

  // Keep the low z bits of a counter and left-align them into ZOOM_MAX bits.
  // Only the low ZOOM_MAX counter bits can ever matter, so only those are passed.
  function automatic logic [PZ_ZOOM_MAX-1:0] pz_frac(
    input logic [PZ_ZOOM_MAX-1:0] low_bits,
    input logic [PZ_ZOOM_W-1:0]   z
  );
    logic [PZ_ZOOM_MAX-1:0] kept;
    kept = low_bits & ~({PZ_ZOOM_MAX{1'b1}} << z);
    return kept << (PZ_ZOOM_MAX - int'(z));
  endfunction

endpackage

// File: rtl/pan_zoom_cfg_shadow.sv
// Config handshake with pending/active shadow registers, committed at frame start.
// Latency: committed config is visible combinationally in the frame-start cycle.
// Backpressure: cfg_ready_out is low while a config is pending (one outstanding).
//
// Ports: clk_in/rst_n_in clock and async active-low reset; cfg_valid_in,
// cfg_ready_out, cfg_in offered config; frame_start_in marks pixel (0,0);
// cfg_eff_out config that applies to the pixel entering the pipe this cycle.
module pan_zoom_cfg_shadow
  import pan_zoom_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic cfg_valid_in,
  output logic cfg_ready_out,
  input  cfg_t cfg_in,
  input  logic frame_start_in,
  output cfg_t cfg_eff_out
);

  cfg_t active_q;
  cfg_t pending_q;
  cfg_t cfg_sat;
  logic pending_vld_q;
  logic ready_q;
  logic accept;
  logic commit;
  logic [PZ_ZOOM_W:0] zoom_ext;

  always_comb begin
    cfg_sat  = cfg_in;
    zoom_ext = {1'b0, cfg_in.zoom};
    if (zoom_ext > PZ_ZOOM_MAX_EXT) begin
      cfg_sat.zoom = PZ_ZOOM_SAT;
    end
  end

  // Ready is only high with nothing pending, so accept and commit are
  // mutually exclusive; an accept in the frame-start cycle waits a frame.
  assign accept = cfg_valid_in && ready_q;
  assign commit = frame_start_in && pending_vld_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_q      <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      if (accept) begin
        pending_q     <= cfg_sat;
        pending_vld_q <= 1'b1;
        ready_q       <= 1'b0;
      end else if (commit) begin
        active_q      <= pending_q;
        pending_vld_q <= 1'b0;
        ready_q       <= 1'b1;
      end else if (!pending_vld_q) begin
        ready_q <= 1'b1;
      end
    end
  end

  // The committing pixel itself already uses the new config.
  assign cfg_eff_out   = commit ? pending_q : active_q;
  assign cfg_ready_out = ready_q;

endmodule

// File: rtl/pan_zoom_addr_gen.sv
// Pan/zoom source-address generator: display counters -> frame-buffer address.
// Latency: 3 cycles, all outputs registered and aligned; one pixel per cycle.
// Backpressure: none on the pixel path; config handshake via cfg_valid/ready.
//
// Ports: hcount_in/vcount_in display counters; cfg_* pan/zoom/clamp config with
// valid/ready; src_x/src_y frame coordinates, frac_x/frac_y left-aligned
// sub-pixel phase, addr_out linear BRAM address, hcount/vcount_out delayed
// counters, valid_out pixel maps into the frame.
module pan_zoom_addr_gen
  import pan_zoom_pkg::*;
#(
  parameter int FRAME_WIDTH  = PZ_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = PZ_FRAME_HEIGHT,
  parameter int DISP_WIDTH   = PZ_DISP_WIDTH,
  parameter int DISP_HEIGHT  = PZ_DISP_HEIGHT,
  parameter int H_W          = PZ_H_W,
  parameter int V_W          = PZ_V_W,
  parameter int ZOOM_MAX     = PZ_ZOOM_MAX,
  parameter int ADDR_W       = $clog2(FRAME_WIDTH * FRAME_HEIGHT)
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [H_W-1:0]                   hcount_in,
  input  logic [V_W-1:0]                   vcount_in,
  input  logic                             cfg_valid_in,
  output logic                             cfg_ready_out,
  input  logic [H_W-1:0]                   cfg_h_offset_in,
  input  logic [V_W-1:0]                   cfg_v_offset_in,
  input  logic [$clog2(ZOOM_MAX+1)-1:0]    cfg_zoom_in,
  input  logic                             cfg_clamp_in,
  output logic [$clog2(FRAME_WIDTH)-1:0]   src_x_out,
  output logic [$clog2(FRAME_HEIGHT)-1:0]  src_y_out,
  output logic [ZOOM_MAX-1:0]              frac_x_out,
  output logic [ZOOM_MAX-1:0]              frac_y_out,
  output logic [ADDR_W-1:0]                addr_out,
  output logic [H_W-1:0]                   hcount_out,
  output logic [V_W-1:0]                   vcount_out,
  output logic                             valid_out
);

  localparam int FXW     = $clog2(FRAME_WIDTH);
  localparam int FYW     = $clog2(FRAME_HEIGHT);
  localparam int X_MAX_I = FRAME_WIDTH - 1;
  localparam int Y_MAX_I = FRAME_HEIGHT - 1;

  localparam logic [H_W:0]   DISP_W_LIM = DISP_WIDTH[H_W:0];
  localparam logic [V_W:0]   DISP_H_LIM = DISP_HEIGHT[V_W:0];
  localparam logic [H_W:0]   X_LIM      = FRAME_WIDTH[H_W:0];
  localparam logic [V_W:0]   Y_LIM      = FRAME_HEIGHT[V_W:0];
  localparam logic [FXW-1:0] X_MAX      = X_MAX_I[FXW-1:0];
  localparam logic [FYW-1:0] Y_MAX      = Y_MAX_I[FYW-1:0];

  // --------------------------------------------------------------------------
  // Config shadow
  // --------------------------------------------------------------------------
  cfg_t cfg_req;
  cfg_t cfg_eff;
  logic frame_start;

  always_comb begin
    cfg_req       = '0;
    cfg_req.h_off = cfg_h_offset_in;
    cfg_req.v_off = cfg_v_offset_in;
    cfg_req.zoom  = cfg_zoom_in;
    cfg_req.clamp = cfg_clamp_in ? MODE_CLAMP : MODE_MASK;
  end

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  pan_zoom_cfg_shadow u_cfg_shadow (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .cfg_valid_in   (cfg_valid_in),
    .cfg_ready_out  (cfg_ready_out),
    .cfg_in         (cfg_req),
    .frame_start_in (frame_start),
    .cfg_eff_out    (cfg_eff)
  );

  // --------------------------------------------------------------------------
  // Stage 1: display window, zoom shift, sub-pixel phase, config snapshot
  // --------------------------------------------------------------------------
  s1_t s1_d;
  s1_t s1_q;

  always_comb begin
    s1_d        = '0;
    s1_d.win    = ({1'b0, hcount_in} < DISP_W_LIM) && ({1'b0, vcount_in} < DISP_H_LIM);
    s1_d.sx     = hcount_in >> cfg_eff.zoom;
    s1_d.sy     = vcount_in >> cfg_eff.zoom;
    s1_d.frac_x = pz_frac(hcount_in[ZOOM_MAX-1:0], cfg_eff.zoom);
    s1_d.frac_y = pz_frac(vcount_in[ZOOM_MAX-1:0], cfg_eff.zoom);
    s1_d.h_off  = cfg_eff.h_off;
    s1_d.v_off  = cfg_eff.v_off;
    s1_d.clamp  = cfg_eff.clamp;
    s1_d.hcount = hcount_in;
    s1_d.vcount = vcount_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: pan offset (one bit of headroom), edge clamp or mask
  // --------------------------------------------------------------------------
  s2_t          s2_d;
  s2_t          s2_q;
  logic [H_W:0] x_sum;
  logic [V_W:0] y_sum;
  logic         x_oob;
  logic         y_oob;
  logic         pix_vld;

  always_comb begin
    s2_d    = '0;
    x_sum   = {1'b0, s1_q.h_off} + {1'b0, s1_q.sx};
    y_sum   = {1'b0, s1_q.v_off} + {1'b0, s1_q.sy};
    x_oob   = x_sum >= X_LIM;
    y_oob   = y_sum >= Y_LIM;
    pix_vld = s1_q.win && ((!x_oob && !y_oob) || (s1_q.clamp == MODE_CLAMP));

    s2_d.vld    = pix_vld;
    s2_d.hcount = s1_q.hcount;
    s2_d.vcount = s1_q.vcount;
    // Invalid pixels carry zero coordinates so the address stage yields 0.
    if (pix_vld) begin
      s2_d.x      = x_oob ? X_MAX : x_sum[FXW-1:0];
      s2_d.y      = y_oob ? Y_MAX : y_sum[FYW-1:0];
      s2_d.frac_x = s1_q.frac_x;
      s2_d.frac_y = s1_q.frac_y;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_q <= '0;
    end else begin
      s2_q <= s2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: linear address and output registers
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_d;

  generate
    if ((FRAME_WIDTH & (FRAME_WIDTH - 1)) == 0) begin : g_addr_shift
      always_comb addr_d = ADDR_W'({s2_q.y, s2_q.x});
    end else begin : g_addr_mult
      always_comb addr_d = ADDR_W'(s2_q.y) * ADDR_W'(FRAME_WIDTH) + ADDR_W'(s2_q.x);
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      src_x_out  <= '0;
      src_y_out  <= '0;
      frac_x_out <= '0;
      frac_y_out <= '0;
      addr_out   <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      src_x_out  <= s2_q.x;
      src_y_out  <= s2_q.y;
      frac_x_out <= s2_q.frac_x;
      frac_y_out <= s2_q.frac_y;
      addr_out   <= addr_d;
      hcount_out <= s2_q.hcount;
      vcount_out <= s2_q.vcount;
      valid_out  <= s2_q.vld;
    end
  end

endmodule

// File: tb/tb_pan_zoom_addr_gen.sv
// Directed bench for pan_zoom_addr_gen with hand-computed expected values.
// Latency: checks outputs exactly 3 clocks after each driven pixel.
// Backpressure: config offered only when ready, with a bounded wait.
module tb_pan_zoom_addr_gen;

  localparam int H_W    = 11;
  localparam int V_W    = 10;
  localparam int ADDR_W = 18;
  localparam int IDLE_H = 2000;
  localparam int IDLE_V = 1000;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b1;
  logic [H_W-1:0]    hcount_in = '0;
  logic [V_W-1:0]    vcount_in = '0;
  logic              cfg_valid_in = 1'b0;
  logic              cfg_ready_out;
  logic [H_W-1:0]    cfg_h_offset_in = '0;
  logic [V_W-1:0]    cfg_v_offset_in = '0;
  logic [1:0]        cfg_zoom_in = '0;
  logic              cfg_clamp_in = 1'b0;
  logic [8:0]        src_x_out;
  logic [8:0]        src_y_out;
  logic [2:0]        frac_x_out;
  logic [2:0]        frac_y_out;
  logic [ADDR_W-1:0] addr_out;
  logic [H_W-1:0]    hcount_out;
  logic [V_W-1:0]    vcount_out;
  logic              valid_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  pan_zoom_addr_gen dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .cfg_valid_in    (cfg_valid_in),
    .cfg_ready_out   (cfg_ready_out),
    .cfg_h_offset_in (cfg_h_offset_in),
    .cfg_v_offset_in (cfg_v_offset_in),
    .cfg_zoom_in     (cfg_zoom_in),
    .cfg_clamp_in    (cfg_clamp_in),
    .src_x_out       (src_x_out),
    .src_y_out       (src_y_out),
    .frac_x_out      (frac_x_out),
    .frac_y_out      (frac_y_out),
    .addr_out        (addr_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .valid_out       (valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input int v, input int x, input int y,
                         input int fx, input int fy, input int a, input int h, input int vc);
    chk({tag, ".valid"},  32'(valid_out),  v);
    chk({tag, ".src_x"},  32'(src_x_out),  x);
    chk({tag, ".src_y"},  32'(src_y_out),  y);
    chk({tag, ".frac_x"}, 32'(frac_x_out), fx);
    chk({tag, ".frac_y"}, 32'(frac_y_out), fy);
    chk({tag, ".addr"},   32'(addr_out),   a);
    chk({tag, ".hcount"}, 32'(hcount_out), h);
    chk({tag, ".vcount"}, 32'(vcount_out), vc);
  endtask

  // Drive one pixel for one clock; inputs change 1 time unit after the edge.
  task automatic px(input int h, input int v);
    hcount_in = H_W'(h);
    vcount_in = V_W'(v);
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) px(IDLE_H, IDLE_V);
  endtask

  // Offer a config and hold it until accepted (bounded); counters are left as
  // the caller set them for the accepting edge, then parked on an idle pixel.
  task automatic cfg_send(input int ho, input int vo, input int z, input bit cl);
    int waited;
    waited          = 0;
    cfg_h_offset_in = H_W'(ho);
    cfg_v_offset_in = V_W'(vo);
    cfg_zoom_in     = 2'(z);
    cfg_clamp_in    = cl;
    cfg_valid_in    = 1'b1;
    while (!cfg_ready_out && waited < 50) begin
      @(posedge clk_in);
      #1;
      waited++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready_out), 1);
    @(posedge clk_in);
    #1;
    cfg_valid_in = 1'b0;
    hcount_in    = H_W'(IDLE_H);
    vcount_in    = V_W'(IDLE_V);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    hcount_in = H_W'(IDLE_H);
    vcount_in = V_W'(IDLE_V);

    // Reset state
    #2 rst_n_in = 1'b0;
    #1;
    chk_pix("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.ready", 32'(cfg_ready_out), 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("rst.ready_held", 32'(cfg_ready_out), 0);
    rst_n_in = 1'b1;
    chk("rst.ready_before_clk", 32'(cfg_ready_out), 0);
    idle(1);
    chk("rst.ready_after_clk", 32'(cfg_ready_out), 1);

    // Identity mapping: 50*512+100
    px(100, 50); idle(2);
    chk_pix("ident", 1, 100, 50, 0, 0, 25700, 100, 50);

    // Mid-frame accept: old mapping holds until pixel (0,0)
    cfg_send(64, 32, 1, 1'b0);
    chk("pend.ready_low", 32'(cfg_ready_out), 0);
    px(101, 50); idle(2);
    chk_pix("old_map", 1, 101, 50, 0, 0, 25701, 101, 50);
    chk("pend.ready_still_low", 32'(cfg_ready_out), 0);
    px(0, 0);
    chk("commit.ready_high", 32'(cfg_ready_out), 1);
    idle(2);
    chk_pix("commit_pix", 1, 64, 32, 0, 0, 16448, 0, 0);
    px(101, 50); idle(2);
    chk_pix("zoom1", 1, 114, 57, 4, 0, 29298, 101, 50);

    // Accept exactly at frame start: applies one frame later
    hcount_in = '0;
    vcount_in = '0;
    cfg_send(500, 0, 0, 1'b1);
    idle(2);
    chk_pix("accept_at_fs", 1, 64, 32, 0, 0, 16448, 0, 0);
    chk("accept_at_fs.ready", 32'(cfg_ready_out), 0);
    px(20, 0); idle(2);
    chk_pix("still_old", 1, 74, 32, 0, 0, 16458, 20, 0);
    px(0, 0); idle(2);
    chk_pix("next_frame", 1, 500, 0, 0, 0, 500, 0, 0);

    // Clamp mode: x=520 saturates; both axes saturate to the last pixel
    px(20, 0); idle(2);
    chk_pix("clamp_x", 1, 511, 0, 0, 0, 511, 20, 0);
    px(20, 600); idle(2);
    chk_pix("clamp_xy", 1, 511, 511, 0, 0, 262143, 20, 600);

    // Mask mode: last in-frame column valid, one past it masked
    cfg_send(500, 0, 0, 1'b0);
    px(0, 0); idle(2);
    chk_pix("mask_fs", 1, 500, 0, 0, 0, 500, 0, 0);
    px(11, 0); idle(2);
    chk_pix("mask_edge", 1, 511, 0, 0, 0, 511, 11, 0);
    px(12, 0); idle(2);
    chk_pix("mask_out", 0, 0, 0, 0, 0, 0, 12, 0);

    // Zoom request of 7 lands as the maximum shift of 3
    cfg_send(0, 0, 7, 1'b0);
    px(0, 0); idle(2);
    chk_pix("zoom3_fs", 1, 0, 0, 0, 0, 0, 0, 0);
    px(13, 22); idle(2);
    chk_pix("zoom3", 1, 1, 2, 5, 6, 1025, 13, 22);
    px(1023, 767); idle(2);
    chk_pix("win_corner", 1, 127, 95, 7, 7, 48767, 1023, 767);

    // Outside the display window
    px(1100, 50); idle(2);
    chk_pix("hwin", 0, 0, 0, 0, 0, 0, 1100, 50);
    px(100, 800); idle(2);
    chk_pix("vwin", 0, 0, 0, 0, 0, 0, 100, 800);
    px(1024, 0); idle(2);
    chk_pix("hwin_edge", 0, 0, 0, 0, 0, 0, 1024, 0);

    // Back-to-back pixels emerge one per clock
    px(8, 8); px(16, 8); px(24, 8);
    chk_pix("stream0", 1, 1, 1, 0, 0, 513, 8, 8);
    idle(1);
    chk_pix("stream1", 1, 2, 1, 0, 0, 514, 16, 8);
    idle(1);
    chk_pix("stream2", 1, 3, 1, 0, 0, 515, 24, 8);

    // Async reset with a pending config: outputs clear at once, config lost
    cfg_send(64, 32, 1, 1'b0);
    px(100, 50); idle(2);
    chk_pix("pre_rst", 1, 12, 6, 4, 2, 3084, 100, 50);
    #2 rst_n_in = 1'b0;
    #1;
    chk_pix("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("async_rst.ready", 32'(cfg_ready_out), 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    chk("post_rst.ready_before_clk", 32'(cfg_ready_out), 0);
    px(0, 0);
    chk("post_rst.ready", 32'(cfg_ready_out), 1);
    idle(2);
    chk_pix("post_rst_fs", 1, 0, 0, 0, 0, 0, 0, 0);
    px(100, 50); idle(2);
    chk_pix("post_rst", 1, 100, 50, 0, 0, 25700, 100, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pan_zoom_addr_gen.md
Name: pan_zoom_addr_gen

Overview:
- Pipelined pan/zoom source-address generator between the video timing generator and the frame-buffer BRAM read port.
- Maps display counters to frame-buffer coordinates: power-of-two zoom, unsigned pan offsets, edge clamp or mask.
- Outputs a linear BRAM address and fractional phase bits for downstream interpolation.
- Offset/zoom changes use a valid/ready config handshake and take effect only at frame start, so no tearing.

Parameters:
FRAME_WIDTH, 512, stored frame width in pixels
FRAME_HEIGHT, 512, stored frame height in pixels
DISP_WIDTH, 1024, active display width (hcount range mapped)
DISP_HEIGHT, 768, active display height
H_W, 11, hcount/h_offset width
V_W, 10, vcount/v_offset width
ZOOM_MAX, 3, max zoom shift (zoom = 2^z, z in 0..ZOOM_MAX)
ADDR_W, $clog2(FRAME_WIDTH*FRAME_HEIGHT), BRAM address width

Ports:
clk_in  input  1  system/pixel clock
rst_n_in  input  1  asynchronous, active-low reset
hcount_in  input  H_W  display horizontal counter
vcount_in  input  V_W  display vertical counter
cfg_valid_in  input  1  new config offered
cfg_ready_out  output  1  config accepted when valid&&ready
cfg_h_offset_in  input  H_W  pan x
cfg_v_offset_in  input  V_W  pan y
cfg_zoom_in  input  $clog2(ZOOM_MAX+1)  zoom shift
cfg_clamp_in  input  1  1=clamp to edge, 0=mask out-of-frame
src_x_out  output  $clog2(FRAME_WIDTH)  frame x
src_y_out  output  $clog2(FRAME_HEIGHT)  frame y
frac_x_out  output  ZOOM_MAX  sub-pixel phase x, left-aligned
frac_y_out  output  ZOOM_MAX  sub-pixel phase y, left-aligned
addr_out  output  ADDR_W  src_y*FRAME_WIDTH+src_x
hcount_out  output  H_W  hcount_in delayed 3 cycles
vcount_out  output  V_W  vcount_in delayed 3 cycles
valid_out  output  1  address valid for this pixel

Behaviour:
- Reset (async assert): all outputs 0; cfg_ready_out 0 while reset is asserted, 1 from the first clock after deassert. Active and pending config cleared (offset 0, zoom 0, clamp 0).
- Latency is exactly 3 cycles; all outputs are registered and mutually aligned.
- Config registers:
  - Handshake accepted when cfg_valid_in && cfg_ready_out. Captured into pending; cfg_ready_out drops the next cycle.
  - cfg_zoom_in > ZOOM_MAX saturates to ZOOM_MAX at capture.
- Frame start = cycle with hcount_in==0 && vcount_in==0. If pending is set, pending→active in that cycle and the new config applies to that pixel; cfg_ready_out returns 1 the next cycle.
- Accept coinciding with frame start: new values go to pending and apply at the following frame start.
- Stage 1:
  - win = hcount_in<DISP_WIDTH && vcount_in<DISP_HEIGHT.
  - sx = hcount_in>>z, sy = vcount_in>>z.
  - frac = low z bits, left-aligned into ZOOM_MAX bits, zero-filled.
- Stage 2:
  - x = h_off + sx, y = v_off + sy, computed one bit wider than the operands (no wrap).
  - Out-of-frame when x>=FRAME_WIDTH or y>=FRAME_HEIGHT.
  - Clamp mode: saturate the offending axis to FRAME_WIDTH-1 / FRAME_HEIGHT-1 and keep valid.
  - Mask mode: valid=0.
- Stage 3: addr = y*FRAME_WIDTH+x. Use a shift when FRAME_WIDTH is a power of two, otherwise a multiply.
- valid_out = win && in-frame/clamped. When valid_out=0, src/addr/frac are don't-care but are driven to 0.
- Config changes never alter pixels already in flight.

Decomposition:
- Package pan_zoom_pkg:
  - clamp-mode enum (MODE_MASK, MODE_CLAMP).
  - cfg struct {h_off, v_off, zoom, clamp}.
  - Stage-payload structs.
  - Derived localparams for coordinate widths.
- One natural sub-module: pan_zoom_cfg_shadow (handshake, pending/active registers, frame-start commit). The datapath stays in the top.

Test Plan:
- Reset, zoom 0, offsets 0; hcount=100, vcount=50 → 3 cycles later src=(100,50), addr=25700, valid_out=1, hcount_out=100.
- Config zoom=1, offset (64,32) committed at frame start; hcount=101, vcount=50 → src=(114,57), frac_x=3'b100, frac_y=0, addr=29298.
- Config offset (500,0), zoom 0; hcount=20, vcount=0 → raw x=520. Clamp mode: src_x=511, valid=1. Mask mode: valid=0.
- Config accepted mid-frame → cfg_ready_out low and old mapping persists until pixel (0,0); the new mapping applies at (0,0); ready high next cycle. Repeat with accept exactly at (0,0) → applies one frame later. Repeat with cfg_zoom_in=7 → zoom 3.
- hcount=1100 or vcount=800 → valid_out=0, addr=0.
- Assert rst_n_in mid-frame with pending config → outputs 0 immediately (asynchronous). After release, mapping is identity and the pending config is lost.
